// File: rtl/tictactoe_btn_arb_if.sv
// tictactoe_btn_arb_if: raw push-buttons and enable in, one-cycle command pulses and busy out.
interface tictactoe_btn_arb_if;
    logic BtnC_raw, BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw, en;
    logic BtnC, BtnU, BtnD, BtnL, BtnR, busy;
    modport master (
        output BtnC_raw, BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw, en,
        input  BtnC, BtnU, BtnD, BtnL, BtnR, busy
    );
    modport slave (
        input  BtnC_raw, BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw, en,
        output BtnC, BtnU, BtnD, BtnL, BtnR, busy
    );
endinterface

// File: rtl/tictactoe_btn_arb.sv
// tictactoe_btn_arb: synchronise, debounce and arbitrate five buttons into one-cycle command pulses.
// Defining BTN_REPEAT_EN adds hold-to-repeat on U/D/L/R.
module tictactoe_btn_arb #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input logic Clk,
    input logic reset,
    tictactoe_btn_arb_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, FIRE, WAIT_REL} state_t;
    state_t state_q, state_d;
    logic [4:0] raw, sync1_q, sync2_q, lvl_q, lvl_d, prio, pulse_q, pulse_d;
    logic [4:0][DW-1:0] cnt_q, cnt_d;
    // LSB-first order C,U,D,L,R makes the lowest set bit the priority winner
    assign raw  = {bus.BtnR_raw, bus.BtnL_raw, bus.BtnD_raw, bus.BtnU_raw, bus.BtnC_raw};
    assign prio = lvl_q & (~lvl_q + 5'd1);
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int i = 0; i < 5; i++)
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DW'(DEB_CYCLES)) lvl_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
    end
`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [4:0] win_q;
    logic rpt_ok;
    // a discarded press latches no winner, so it can never repeat
    assign rpt_ok = |win_q && !win_q[0] && lvl_q == win_q;
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            rcnt_q <= '0;
        end else begin
            if (state_q == IDLE) win_q <= bus.en ? prio : '0;
            rcnt_q <= rcnt_d;
        end
    end
`endif
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        case (state_q)
            IDLE: if (|lvl_q) begin
                state_d = bus.en ? FIRE : WAIT_REL;
                pulse_d = bus.en ? prio : '0;
            end
            FIRE:    state_d = WAIT_REL;
            default: state_d = |lvl_q ? WAIT_REL : IDLE;
        endcase
`ifdef BTN_REPEAT_EN
        rcnt_d = '0;
        if (state_q != IDLE && rpt_ok) rcnt_d = rcnt_q + 1'b1;
        if (state_q == WAIT_REL && rpt_ok && rcnt_q >= RW'(REPEAT_CYCLES - 1)) begin
            rcnt_d  = '0;
            pulse_d = win_q;
        end
`endif
    end
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            pulse_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end
    assign bus.BtnC = pulse_q[0];
    assign bus.BtnU = pulse_q[1];
    assign bus.BtnD = pulse_q[2];
    assign bus.BtnL = pulse_q[3];
    assign bus.BtnR = pulse_q[4];
    assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_tictactoe_btn_arb.sv
// tb_tictactoe_btn_arb: directed button scenarios checked every cycle against a behavioural model.
module tb_tictactoe_btn_arb;
    localparam int DEB = 4;
    localparam int RPT = 8;
    logic Clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] raw = '0;
    logic en = 1'b1;
    int total = 0;
    int bad = 0;
    tictactoe_btn_arb_if bi();
    assign bi.BtnC_raw = raw[0];
    assign bi.BtnU_raw = raw[1];
    assign bi.BtnD_raw = raw[2];
    assign bi.BtnL_raw = raw[3];
    assign bi.BtnR_raw = raw[4];
    assign bi.en       = en;
    tictactoe_btn_arb #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (.Clk(Clk), .reset(reset), .bus(bi));
    logic [4:0] pulse;
    assign pulse = {bi.BtnR, bi.BtnL, bi.BtnD, bi.BtnU, bi.BtnC};
    always #5 Clk = ~Clk;

    // Model: a level flips once DEB+1 consecutive synchronised samples (raw delayed two edges) disagree with it
    logic [4:0] hist [0:1023];
    logic [4:0] lvl = '0, exp_pulse = '0, latched = '0;
    logic exp_busy = 1'b0, just_fired = 1'b0;
    int t = 0, since = 0, m_cnt = 0, m_last = -1;
    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            t = 0; lvl = '0; exp_pulse = '0; latched = '0; exp_busy = 1'b0;
            just_fired = 1'b0; since = 0; m_cnt = 0; m_last = -1;
        end else begin : edge_step
            logic [4:0] prev;
            logic diff;
            prev = lvl;
            if (t < 1024) hist[t] = raw;
            for (int b = 0; b < 5; b++) begin
                diff = (t >= DEB + 2) && (t < 1024);
                for (int k = 0; k <= DEB; k++)
                    if (diff && hist[t-2-k][b] == lvl[b]) diff = 1'b0;
                if (diff) lvl[b] = ~lvl[b];
            end
            exp_pulse = '0;
            if (!exp_busy) begin
                if (prev != 0) begin
                    exp_busy = 1'b1;
                    since = 0;
                    just_fired = en;
                    latched = en ? (prev & (~prev + 5'd1)) : 5'd0;
                    if (en) begin exp_pulse = latched; m_cnt++; m_last = t; end
                end
            end else begin
                if (!just_fired && prev == 0) exp_busy = 1'b0;
`ifdef BTN_REPEAT_EN
                else if (latched != 0 && !latched[0] && prev == latched) begin
                    since++;
                    if (!just_fired && since >= RPT) begin exp_pulse = latched; since = 0; m_cnt++; m_last = t; end
                end else since = 0;
`endif
                just_fired = 1'b0;
            end
            t++;
        end
    end

    int d_cnt = 0, d_last = -1;
    logic [4:0] d_bits = '0;
    always @(negedge Clk) begin
        total++;
        if (pulse !== exp_pulse) begin bad++; $display("FAIL pulse cyc=%0d got=%b exp=%b", t - 1, pulse, exp_pulse); end
        total++;
        if (bi.busy !== exp_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", t - 1, bi.busy, exp_busy); end
        total++;
        if ($countones(pulse) > 1) begin bad++; $display("FAIL onehot cyc=%0d got=%b exp=at most one bit", t - 1, pulse); end
        if (reset) begin d_cnt = 0; d_last = -1; d_bits = '0; end
        else if (pulse != 0) begin d_cnt++; d_last = t - 1; d_bits = pulse; end
    end

    task automatic check(input string nm, input int got, input int expv);
        total++;
        if (got != expv) begin bad++; $display("FAIL %s got=%0d exp=%0d", nm, got, expv); end
    endtask
    task automatic tick(input int n);
        repeat (n) begin @(posedge Clk); #2; end
    endtask
    task automatic start(input logic [4:0] r, input logic e);
        reset = 1'b1; raw = '0; en = 1'b1;
        tick(3);
        raw = r; en = e; reset = 1'b0;
    endtask

    initial begin
        #1;
        start(5'b00010, 1'b1);
        tick(30);
        check("u_model_cycle", m_last, 7);
        check("u_dut_cycle", d_last, 7);
        check("u_count", d_cnt, 1);
        check("u_busy_held", int'(bi.busy), 1);
        raw = '0;
        tick(15);
        check("u_busy_released", int'(bi.busy), 0);

        start(5'b00001, 1'b1);
        for (int k = 0; k < 20; k++) begin raw[0] = ((k / 2) % 2 == 0); tick(1); end
        raw[0] = 1'b1;
        tick(15);
        check("c_bounce_model_cycle", m_last, 27);
        check("c_bounce_dut_cycle", d_last, 27);
        check("c_bounce_count", d_cnt, 1);

        start(5'b01010, 1'b1);
        tick(20);
        check("ul_cycle", d_last, 7);
        check("ul_bits", int'(d_bits), 2);
        raw = 5'b01000;
        tick(20);
        check("ul_l_never_fires", d_cnt, 1);
        check("ul_busy_l_held", int'(bi.busy), 1);
        raw = '0;
        tick(15);
        check("ul_busy_released", int'(bi.busy), 0);

        start(5'b10000, 1'b0);
        tick(10);
        en = 1'b1;
        tick(10);
        check("r_discard_count", d_cnt, 0);
        raw = '0;
        tick(15);
        check("r_idle_before_repress", int'(bi.busy), 0);
        raw = 5'b10000;
        tick(12);
        check("r_repress_model_cycle", m_last, 42);
        check("r_repress_dut_cycle", d_last, 42);
        check("r_repress_count", d_cnt, 1);

        start(5'b10000, 1'b1);
        tick(41);
`ifdef BTN_REPEAT_EN
        check("r_hold_count", d_cnt, 5);
        check("r_hold_last", d_last, 39);
`else
        check("r_hold_count", d_cnt, 1);
        check("r_hold_last", d_last, 7);
`endif
        raw = '0;
        tick(15);

        start(5'b00100, 1'b1);
        tick(8);
        check("d_pulse_before_reset", int'(pulse), 4);
        reset = 1'b1;
        #1;
        check("d_pulse_in_reset", int'(pulse), 0);
        check("d_busy_in_reset", int'(bi.busy), 0);
        tick(3);
        reset = 1'b0;
        tick(12);
        check("d_after_reset_model_cycle", m_last, 7);
        check("d_after_reset_dut_cycle", d_last, 7);
        check("d_after_reset_count", d_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tictactoe_btn_arb.md
TICTACTOE_BTN_ARB -- requirements
Module: tictactoe_btn_arb

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000; number of consecutive stable synchronized samples required to change a debounced level (≥1).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000; hold-to-repeat period in cycles (≥1), used only under REQ-024.
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports BtnC_raw, BtnU_raw, BtnD_raw, BtnL_raw, BtnR_raw  input  1 each  raw, unsynchronized, bouncing push-buttons.
REQ-006 SHALL have port en  input  1  move-acceptance enable, driven from the game state machine's game output.
REQ-007 SHALL have ports BtnC, BtnU, BtnD, BtnL, BtnR  output  1 each  registered one-cycle command pulses to the game state machine.
REQ-008 SHALL have port busy  output  1  high whenever the arbiter FSM is not in IDLE.

Function
REQ-009 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep one debounce counter per button, of width ceil(log2(DEB_CYCLES+1)); it clears when the synchronized sample equals the debounced level and increments otherwise; on reaching DEB_CYCLES, the debounced level takes the sample and the counter clears.
REQ-011 SHALL give a raw level held stable from cycle 0 a debounced level change at cycle 2+DEB_CYCLES.
REQ-012 SHALL implement FSM states IDLE, FIRE and WAIT_REL.
REQ-013 IDLE SHALL go to FIRE when en=1 and any debounced level is 1, latching the winner by fixed priority C > U > D > L > R.
REQ-014 IDLE SHALL go to WAIT_REL without any pulse when en=0 and any debounced level is 1; that press is discarded.
REQ-015 FIRE SHALL assert exactly the latched output for exactly one cycle, with all other pulse outputs 0, then go to WAIT_REL.
REQ-016 WAIT_REL SHALL return to IDLE only when all five debounced levels are 0; presses of other buttons in WAIT_REL are ignored.
REQ-017 A press held stable from cycle 0 with en=1 SHALL produce its pulse in cycle 3+DEB_CYCLES.
REQ-018 At most one pulse output SHALL be 1 in any cycle.
REQ-019 Simultaneous debounced presses SHALL yield only the highest-priority pulse; a lower-priority button still held afterwards SHALL NOT fire until all buttons are released and re-pressed.
REQ-020 en falling while in FIRE or WAIT_REL SHALL NOT cancel a pulse already in FIRE.

Reset
REQ-021 While reset=1, the block SHALL hold the FSM in IDLE, all synchronizer flops, debounced levels and counters at 0, and all outputs (BtnC..BtnR, busy) at 0.
REQ-022 A reset asserted mid-FIRE SHALL suppress that pulse immediately.
REQ-023 After reset release, a button still held SHALL be treated as a new press, firing per REQ-017 with cycle 0 taken as the first cycle after release.

Configuration
REQ-024 With macro BTN_REPEAT_EN defined, WAIT_REL SHALL run a repeat counter of width ceil(log2(REPEAT_CYCLES+1)) while the latched button is U, D, L or R and is the only debounced-high button.
REQ-025 Under BTN_REPEAT_EN, the block SHALL re-issue that pulse for one cycle each time the repeat counter reaches REPEAT_CYCLES, then clear the counter; the counter SHALL clear on entry to WAIT_REL or when the condition drops; BtnC never repeats.
REQ-026 Without BTN_REPEAT_EN, the block SHALL NOT build the repeat logic, and each press SHALL produce exactly one pulse.

Verification (bench: DEB_CYCLES=4, REPEAT_CYCLES=8, en=1 unless stated)
REQ-027 Stimulus: BtnU_raw=1 at cycle 0 and held. Response: BtnU=1 in cycle 7 only, busy=1 from cycle 7 until release is debounced.
REQ-028 Stimulus: BtnC_raw toggles every 2 cycles for cycles 0-19, then held 1. Response: no pulse before cycle 20; single BtnC pulse at cycle 27.
REQ-029 Stimulus: BtnU_raw and BtnL_raw rise at cycle 0 and both are held. Response: only BtnU at cycle 7; BtnL is never pulsed; releasing U while L is held gives no pulse.
REQ-030 Stimulus: en=0, BtnR_raw pressed at cycle 0, en=1 at cycle 10, R still held. Response: no pulse; R is released then re-pressed; R re-press gives BtnR 7 cycles after the re-press.
REQ-031 Stimulus: BtnR_raw held for 40 cycles. Response: BTN_REPEAT_EN defined: BtnR at cycles 7, 15, 23, 31, 39. BTN_REPEAT_EN undefined: BtnR at cycle 7 only.
REQ-032 Stimulus: reset pulsed at cycle 7 with BtnD_raw held. Response: outputs 0 during reset; BtnD fires 7 cycles after reset release.
